// File: rtl/nibble_serial_tx_if.sv
// nibble_serial_tx_if
//   Bundles the parallel load handshake and the serial-side status lines of
//   the nibble serial transmitter.
//
//   Signals:
//     D       parallel data word, sampled by the transmitter on an accepted load
//     Load    load request (valid-style)
//     Ready   transmitter can accept a load this cycle
//     SerOut  serial line, idles high
//     Busy    a frame is in progress
//     Done    one-cycle pulse after a completed frame
//
//   Modports:
//     master  the side that supplies data and watches the line
//     slave   the transmitter itself
interface nibble_serial_tx_if #(
    parameter int unsigned DATA_W = 4
);
    logic [DATA_W-1:0] D;
    logic              Load;
    logic              Ready;
    logic              SerOut;
    logic              Busy;
    logic              Done;

    modport master (
        output D,
        output Load,
        input  Ready,
        input  SerOut,
        input  Busy,
        input  Done
    );

    modport slave (
        input  D,
        input  Load,
        output Ready,
        output SerOut,
        output Busy,
        output Done
    );
endinterface

// File: rtl/nibble_serial_tx.sv
// nibble_serial_tx
//   Parallel-to-serial transmitter for the 4-bit register datapath. A word is
//   accepted on the Load/Ready handshake and sent on SerOut as a frame:
//   start bit (0), DATA_W data bits LSB first, optional even-parity bit,
//   stop bit (1). Every serial bit is held for BIT_CYCLES clock cycles.
//
//   Ports:
//     Clock   rising-edge clock
//     Resetn  asynchronous, active-low reset
//     tx      nibble_serial_tx_if.slave: D, Load in; Ready, SerOut, Busy,
//             Done out. All outputs come straight from flops.
//
//   Parameters:
//     DATA_W      data bits per frame (1..16)
//     PARITY_EN   1 inserts an even-parity bit after the data
//     BIT_CYCLES  clock cycles per serial bit (>= 1)
module nibble_serial_tx #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    nibble_serial_tx_if.slave    tx
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q,  state_d;
    logic [DATA_W-1:0] shift_q,  shift_d;
    logic [CW-1:0]     cyc_q,    cyc_d;
    logic [BW-1:0]     bit_q,    bit_d;
    logic              par_q,    par_d;
    logic              ser_q,    ser_d;
    logic              ready_q,  ready_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;

    logic              bit_end;
    logic [DATA_W-1:0] shift_nxt;

    assign bit_end   = (cyc_q == CYC_LAST);
    assign shift_nxt = shift_q >> 1;

    // Next-state logic. SerOut is computed one cycle ahead so the line is
    // driven from a flop and changes exactly on the bit boundary.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        par_d   = par_q;
        ser_d   = ser_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (tx.Load) begin
                    state_d = START;
                    shift_d = tx.D;
                    par_d   = 1'b0;
                    cyc_d   = '0;
                    bit_d   = '0;
                    ser_d   = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cyc_d   = '0;
                    ser_d   = shift_q[0];
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_nxt;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            // Accumulator including the bit just finished.
                            ser_d   = par_q ^ shift_q[0];
                        end else begin
                            state_d = STOP;
                            ser_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                        ser_d = shift_nxt[0];
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cyc_d   = '0;
                    ser_d   = 1'b1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cyc_d   = '0;
                bit_d   = '0;
                ser_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            shift_q <= '0;
            cyc_q   <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            ser_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            ser_q   <= ser_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx.SerOut = ser_q;
    assign tx.Ready  = ready_q;
    assign tx.Busy   = busy_q;
    assign tx.Done   = done_q;

endmodule

// File: tb/tb_nibble_serial_tx.sv
module tb_nibble_serial_tx;

    logic Clock;
    logic Resetn;

    int n_checks;
    int n_fails;

    // Instance A: defaults (4 data bits, parity, 4 cycles/bit, F = 28)
    // Instance B: no parity, 1 cycle/bit (F = 6)
    nibble_serial_tx_if #(.DATA_W(4)) bus_a ();
    nibble_serial_tx_if #(.DATA_W(4)) bus_b ();

    nibble_serial_tx #(
        .DATA_W     (4),
        .PARITY_EN  (1),
        .BIT_CYCLES (4)
    ) dut_a (
        .Clock  (Clock),
        .Resetn (Resetn),
        .tx     (bus_a.slave)
    );

    nibble_serial_tx #(
        .DATA_W     (4),
        .PARITY_EN  (0),
        .BIT_CYCLES (1)
    ) dut_b (
        .Clock  (Clock),
        .Resetn (Resetn),
        .tx     (bus_b.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Status vector order: {SerOut, Ready, Busy, Done}

    task automatic test_reset();
        logic [3:0] got;
        Resetn = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        got = {bus_a.SerOut, bus_a.Ready, bus_a.Busy, bus_a.Done};
        n_checks++;
        if (got !== 4'b1100) begin
            n_fails++;
            $display("FAIL reset_hold_a got %b exp 1100", got);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clock);
            #1;
            got = {bus_a.SerOut, bus_a.Ready, bus_a.Busy, bus_a.Done};
            n_checks++;
            if (got !== 4'b1100) begin
                n_fails++;
                $display("FAIL reset_idle_a cycle %0d got %b exp 1100", k, got);
            end
            got = {bus_b.SerOut, bus_b.Ready, bus_b.Busy, bus_b.Done};
            n_checks++;
            if (got !== 4'b1100) begin
                n_fails++;
                $display("FAIL reset_idle_b cycle %0d got %b exp 1100", k, got);
            end
        end
    endtask

    // D=1011: start 0, data 1,1,0,1, parity 1, stop 1
    task automatic test_frame_parity();
        logic [6:0] frame;
        logic [3:0] got, exp;
        frame = 7'b1110110;   // bit 0 = start ... bit 6 = stop
        @(negedge Clock);
        bus_a.D    = 4'b1011;
        bus_a.Load = 1'b1;
        @(posedge Clock);     // t0
        #1;
        bus_a.Load = 1'b0;
        bus_a.D    = 4'b0000; // must not affect the frame in flight
        for (int k = 1; k <= 30; k++) begin
            if (k <= 28)      exp = {frame[(k-1)/4], 3'b010};
            else if (k == 29) exp = 4'b1101;
            else              exp = 4'b1100;
            got = {bus_a.SerOut, bus_a.Ready, bus_a.Busy, bus_a.Done};
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL frame_1011 t0+%0d got %b exp %b", k, got, exp);
            end
            @(posedge Clock);
            #1;
        end
    endtask

    // D=0110, no parity, 1 cycle/bit: 0,0,1,1,0,1 then Done at t0+7
    task automatic test_no_parity_fast();
        logic [5:0] frame;
        logic [3:0] got, exp;
        frame = 6'b101100;
        @(negedge Clock);
        bus_b.D    = 4'b0110;
        bus_b.Load = 1'b1;
        @(posedge Clock);
        #1;
        bus_b.Load = 1'b0;
        bus_b.D    = 4'b1001;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 6)      exp = {frame[k-1], 3'b010};
            else if (k == 7) exp = 4'b1101;
            else             exp = 4'b1100;
            got = {bus_b.SerOut, bus_b.Ready, bus_b.Busy, bus_b.Done};
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL fast_0110 t0+%0d got %b exp %b", k, got, exp);
            end
            @(posedge Clock);
            #1;
        end
    endtask

    // Load held high: A frame, one idle/Done cycle, 5 frame; mid-frame
    // Load pulse ignored and not queued.
    task automatic test_back_to_back();
        logic [6:0] fa, f5;
        logic [3:0] got, exp;
        fa = 7'b1010100;
        f5 = 7'b1001010;
        @(negedge Clock);
        bus_a.D    = 4'hA;
        bus_a.Load = 1'b1;
        @(posedge Clock);
        #1;
        for (int k = 1; k <= 61; k++) begin
            if (k <= 28)      exp = {fa[(k-1)/4], 3'b010};
            else if (k == 29) exp = 4'b1101;
            else if (k <= 57) exp = {f5[(k-30)/4], 3'b010};
            else if (k == 58) exp = 4'b1101;
            else              exp = 4'b1100;
            got = {bus_a.SerOut, bus_a.Ready, bus_a.Busy, bus_a.Done};
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL b2b t0+%0d got %b exp %b", k, got, exp);
            end
            if (k == 10) bus_a.D    = 4'h5;
            if (k == 35) bus_a.Load = 1'b0;
            if (k == 40) bus_a.Load = 1'b1;
            if (k == 41) bus_a.Load = 1'b0;
            @(posedge Clock);
            #1;
        end
    endtask

    // Reset during data bit 2 (cycles t0+13..16), then a fresh 0110 frame.
    task automatic test_reset_mid_frame();
        logic [6:0] frame;
        logic [3:0] got, exp;
        frame = 7'b1001100;   // 0110: data 0,1,1,0 parity 0
        @(negedge Clock);
        bus_a.D    = 4'b1011;
        bus_a.Load = 1'b1;
        @(posedge Clock);
        #1;
        bus_a.Load = 1'b0;
        repeat (13) @(posedge Clock);
        #1;                   // cycle t0+14, bit d2 of 1011 = 0
        got = {bus_a.SerOut, bus_a.Ready, bus_a.Busy, bus_a.Done};
        n_checks++;
        if (got !== 4'b0010) begin
            n_fails++;
            $display("FAIL rst_pre got %b exp 0010", got);
        end
        Resetn = 1'b0;
        #1;
        got = {bus_a.SerOut, bus_a.Ready, bus_a.Busy, bus_a.Done};
        n_checks++;
        if (got !== 4'b1100) begin
            n_fails++;
            $display("FAIL rst_async got %b exp 1100", got);
        end
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clock);
            #1;
            got = {bus_a.SerOut, bus_a.Ready, bus_a.Busy, bus_a.Done};
            n_checks++;
            if (got !== 4'b1100) begin
                n_fails++;
                $display("FAIL rst_no_done cycle %0d got %b exp 1100", k, got);
            end
        end
        @(negedge Clock);
        bus_a.D    = 4'b0110;
        bus_a.Load = 1'b1;
        @(posedge Clock);
        #1;
        bus_a.Load = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            if (k <= 28) exp = {frame[(k-1)/4], 3'b010};
            else         exp = 4'b1101;
            got = {bus_a.SerOut, bus_a.Ready, bus_a.Busy, bus_a.Done};
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL rst_fresh t0+%0d got %b exp %b", k, got, exp);
            end
            @(posedge Clock);
            #1;
        end
    endtask

    // All-zero and all-one data: parity 0 in both, 28-cycle frames.
    task automatic test_parity_extremes();
        logic [6:0] frames [2];
        logic [3:0] data [2];
        logic [3:0] got, exp;
        data[0]   = 4'b0000;
        frames[0] = 7'b1000000;
        data[1]   = 4'b1111;
        frames[1] = 7'b1011110;
        for (int n = 0; n < 2; n++) begin
            @(negedge Clock);
            bus_a.D    = data[n];
            bus_a.Load = 1'b1;
            @(posedge Clock);
            #1;
            bus_a.Load = 1'b0;
            for (int k = 1; k <= 29; k++) begin
                if (k <= 28) exp = {frames[n][(k-1)/4], 3'b010};
                else         exp = 4'b1101;
                got = {bus_a.SerOut, bus_a.Ready, bus_a.Busy, bus_a.Done};
                n_checks++;
                if (got !== exp) begin
                    n_fails++;
                    $display("FAIL parity_%b t0+%0d got %b exp %b",
                             data[n], k, got, exp);
                end
                @(posedge Clock);
                #1;
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        Resetn     = 1'b0;
        bus_a.D    = '0;
        bus_a.Load = 1'b0;
        bus_b.D    = '0;
        bus_b.Load = 1'b0;

        test_reset();
        test_frame_parity();
        test_no_parity_fast();
        test_back_to_back();
        test_reset_mid_frame();
        test_parity_extremes();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
